ready_valid_fifo_sender: RTL

- Producer-side companion to the HAL ready/valid FIFO.
- Accepts a ready/valid stream from user logic and delivers it to a single-clock FIFO write port through a fixed-latency, non-stalling register pipeline. The FIFO write port has wrreq = valid and no per-beat backpressure.
- Guarantees no overflow by gating acceptance with a credit check: the FIFO's used-word count plus the beats in flight must stay below capacity.
- Sits between deep-pipelined producers and the FIFO input, where combinational ready cannot reach the FIFO in one cycle.

---
 rtl/ready_valid_fifo_pkg.sv | 26 ++
 rtl/ready_valid_fifo_sender_delay_line.sv | 40 ++++
 rtl/ready_valid_fifo_sender.sv | 85 ++++++++
 3 files changed

// File: rtl/ready_valid_fifo_pkg.sv
// Shared sizing helpers and parameter-legality checks for the FIFO sender.
package ready_valid_fifo_pkg;

  // Width of the in-flight beat counter; must hold 0 .. latency+1.
  function automatic int unsigned cnt_width(input int unsigned latency);
    return $clog2(latency + 2);
  endfunction

  // Width used for the credit comparison so usedw + inflight cannot wrap.
  function automatic int unsigned cmp_width(input int unsigned log_depth);
    return log_depth + 2;
  endfunction

  // True when the parameter set describes a buildable sender.
  function automatic bit params_legal(input int unsigned depth,
                                      input int unsigned log_depth,
                                      input int unsigned latency,
                                      input int unsigned reserve);
    return (depth >= 2) &&
           ((depth & (depth - 1)) == 0) &&
           (log_depth == $clog2(depth)) &&
           (latency >= 1) &&
           (reserve < depth);
  endfunction

endpackage

// File: rtl/ready_valid_fifo_sender_delay_line.sv
// Fixed-latency, non-stalling shift of {valid, data}; only valid bits are reset.
module valid_data_delay_line #(
  parameter int unsigned WIDTH   = 32,
  parameter int unsigned LATENCY = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  output logic [WIDTH-1:0] out_data
);

  logic [LATENCY-1:0] vld;
  logic [WIDTH-1:0]   dat [LATENCY];

  // Valid chain: cleared on reset so no beat survives a reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      vld <= '0;
    end else begin
      vld[0] <= in_valid;
      for (int unsigned i = 1; i < LATENCY; i++) begin
        vld[i] <= vld[i-1];
      end
    end
  end

  // Data chain: free-running, contents only meaningful alongside valid.
  always_ff @(posedge clk) begin
    dat[0] <= in_data;
    for (int unsigned i = 1; i < LATENCY; i++) begin
      dat[i] <= dat[i-1];
    end
  end

  assign out_valid = vld[LATENCY-1];
  assign out_data  = dat[LATENCY-1];

endmodule

// File: rtl/ready_valid_fifo_sender.sv
// Credit-gated ready/valid front end feeding a FIFO write port through a fixed pipeline.
module ready_valid_fifo_sender
  import ready_valid_fifo_pkg::*;
#(
  parameter int unsigned WIDTH          = 32,
  parameter int unsigned DEPTH          = 512,
  parameter int unsigned LOG_DEPTH      = $clog2(DEPTH),
  parameter int unsigned LATENCY        = 2,
  parameter int unsigned CREDIT_RESERVE = 0
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           in_valid,
  output logic                           in_ready,
  input  logic [WIDTH-1:0]               in_data,
  output logic                           out_valid,
  output logic [WIDTH-1:0]               out_data,
  input  logic [LOG_DEPTH:0]             fifo_usedw,
  input  logic                           fifo_full,
  output logic [cnt_width(LATENCY)-1:0]  inflight,
  output logic                           overflow_error
);

  localparam int unsigned CNT_W     = cnt_width(LATENCY);
  localparam int unsigned CMP_W     = cmp_width(LOG_DEPTH);
  localparam int unsigned LIMIT     = DEPTH - CREDIT_RESERVE;
  localparam bit          PARAMS_OK = params_legal(DEPTH, LOG_DEPTH, LATENCY, CREDIT_RESERVE);

  if (!PARAMS_OK) begin : g_bad_params
    $error("ready_valid_fifo_sender: illegal DEPTH/LOG_DEPTH/LATENCY/CREDIT_RESERVE");
  end

  logic             accept;
  logic [CMP_W-1:0] credit_used;
  logic [CNT_W-1:0] inflight_next;
  logic             cnt_err;

  // Credit check: only registered state and rst feed ready, never in_valid.
  always_comb begin
    credit_used = CMP_W'(fifo_usedw) + CMP_W'(inflight);
    in_ready    = ~rst & (credit_used < CMP_W'(LIMIT));
    accept      = in_valid & in_ready;
  end

  // In-flight tracking: +1 on accept, -1 once usedw has absorbed the write.
  always_comb begin
    inflight_next = inflight;
    cnt_err       = 1'b0;
    case ({accept, out_valid})
      2'b10: begin
        if (inflight == CNT_W'(LATENCY + 1)) cnt_err = 1'b1;
        else                                 inflight_next = inflight + CNT_W'(1);
      end
      2'b01: begin
        if (inflight == '0) cnt_err = 1'b1;
        else                inflight_next = inflight - CNT_W'(1);
      end
      default: ;
    endcase
  end

  // Counter and sticky error register.
  always_ff @(posedge clk) begin
    if (rst) begin
      inflight       <= '0;
      overflow_error <= 1'b0;
    end else begin
      inflight       <= inflight_next;
      overflow_error <= overflow_error | (out_valid & fifo_full) | cnt_err;
    end
  end

  valid_data_delay_line #(
    .WIDTH   (WIDTH),
    .LATENCY (LATENCY)
  ) u_delay (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (accept),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_data  (out_data)
  );

endmodule
